// File: rtl/mult_shift_add.sv
// mult_shift_add: multi-cycle signed WIDTH x WIDTH radix-2 shift-and-add multiplier.
// Operands are converted to magnitudes on start, multiplied unsigned over WIDTH
// iterations (one multiplier bit per clock), and the sign is re-applied when the
// result is registered. data_result/data_exception hold until the next completion.
// Build option: define MULT_EARLY_TERM_EN to leave RUN as soon as the remaining
// multiplier bits are all zero (minimum one iteration).
module mult_shift_add #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest magnitude a negative result may have (2^(WIDTH-1)); one more than
  // the largest positive magnitude.
  localparam logic [2*WIDTH-1:0] MAG_LIMIT = (2*WIDTH)'(1) << (WIDTH-1);
  localparam logic [CNT_W-1:0]   LAST_ITER = CNT_W'(WIDTH-1);

  state_t             state;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic [CNT_W-1:0]   counter;
  logic               neg;

  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [2*WIDTH-1:0] productSum;
  logic [WIDTH-1:0]   multiplierShift;
  logic [WIDTH-1:0]   productLow;
  logic [WIDTH-1:0]   resultValue;
  logic               overflowFlag;
  logic               runDone;

  // Operand magnitudes, the current iteration's accumulate and the final
  // sign/overflow evaluation, all derived from the pre-edge register values.
  always_comb begin
    magA            = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    magB            = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    productSum      = multiplier[0] ? (product + multiplicand) : product;
    multiplierShift = multiplier >> 1;
    productLow      = productSum[WIDTH-1:0];
    resultValue     = neg ? -productLow : productLow;
    overflowFlag    = neg ? (productSum > MAG_LIMIT) : (productSum >= MAG_LIMIT);
`ifdef MULT_EARLY_TERM_EN
    runDone         = (counter == LAST_ITER) || (multiplierShift == '0);
`else
    runDone         = (counter == LAST_ITER);
`endif
  end

  // Control FSM and datapath registers; a start request always wins, which
  // gives abort-and-restart from RUN and back-to-back issue from DONE.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      product        <= '0;
      multiplicand   <= '0;
      multiplier     <= '0;
      counter        <= '0;
      neg            <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_MULT) begin
        product      <= '0;
        multiplicand <= {{WIDTH{1'b0}}, magA};
        multiplier   <= magB;
        counter      <= '0;
        neg          <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        state        <= RUN;
        busy         <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            product      <= productSum;
            multiplicand <= multiplicand << 1;
            multiplier   <= multiplierShift;
            counter      <= counter + CNT_W'(1);
            if (runDone) begin
              state          <= DONE;
              busy           <= 1'b0;
              data_resultRDY <= 1'b1;
              data_result    <= resultValue;
              data_exception <= overflowFlag;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mult_shift_add.sv
// tb_mult_shift_add: directed vector table plus hand-written sequences for
// abort/restart, restart in the DONE cycle and asynchronous reset mid-operation.
// Cycle n is the clock period that follows rising edge n-1; the start edge is edge 0.
module tb_mult_shift_add;

  localparam int WIDTH = 32;

  logic             clock = 1'b0;
  logic             resetn;
  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  mult_shift_add #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expResult;
    logic        expExc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Cycle in which RDY is expected for multiplier b, counted from the start edge.
  function automatic int expRdyCycle(input logic [31:0] b);
`ifdef MULT_EARLY_TERM_EN
    logic [31:0] m;
    int n;
    m = b[31] ? -b : b;
    n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return n + 1;
`else
    return WIDTH + 1;
`endif
  endfunction

  task automatic startOp(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
  endtask

  // Watch nCycles cycles (sampled mid-cycle); busy must be high exactly in cycles 1..busyUntil.
  task automatic observe(input int nCycles, input int busyUntil, output int rdyCycle,
                         output int rdyCount, output logic [31:0] res, output logic exc,
                         output int busyErr);
    rdyCycle = -1;
    rdyCount = 0;
    busyErr  = 0;
    res      = '0;
    exc      = 1'b0;
    for (int c = 1; c <= nCycles; c++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) begin
        rdyCount++;
        if (rdyCycle < 0) begin
          rdyCycle = c;
          res      = data_result;
          exc      = data_exception;
        end
      end
      if (busy !== (c <= busyUntil)) busyErr++;
    end
  endtask

  initial begin
    vec_t        vecs [12];
    int          rdyCycle, rdyCount, busyErr, er, er2, cut;
    logic [31:0] res;
    logic        exc;

    vecs[0]  = '{32'd7,        32'd6,        32'd42,       1'b0};
    vecs[1]  = '{32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 1'b0};
    vecs[2]  = '{32'h80000000, 32'd1,        32'h80000000, 1'b0};
    vecs[3]  = '{32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
    vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[5]  = '{32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    vecs[7]  = '{32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1};
    vecs[8]  = '{32'h40000000, 32'hFFFFFFFE, 32'h80000000, 1'b0};
    vecs[9]  = '{32'h40000000, 32'd2,        32'h80000000, 1'b1};
    vecs[10] = '{32'd12345,    32'hFFFFFF9C, 32'hFFED29BC, 1'b0};
    vecs[11] = '{32'd9,        32'd3,        32'd27,       1'b0};

    resetn        = 1'b0;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #2;
    check("reset_result", data_result, 32'd0);
    check("reset_exc",    {31'd0, data_exception}, 32'd0);
    check("reset_rdy",    {31'd0, data_resultRDY}, 32'd0);
    check("reset_busy",   {31'd0, busy}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      startOp(vecs[i].a, vecs[i].b);
      er = expRdyCycle(vecs[i].b);
      observe(er + 2, er - 1, rdyCycle, rdyCount, res, exc, busyErr);
      check($sformatf("v%0d_rdy_cycle", i), rdyCycle, er);
      check($sformatf("v%0d_rdy_count", i), rdyCount, 32'd1);
      check($sformatf("v%0d_result", i), res, vecs[i].expResult);
      check($sformatf("v%0d_exc", i), {31'd0, exc}, {31'd0, vecs[i].expExc});
      check($sformatf("v%0d_busy_errs", i), busyErr, 32'd0);
      check($sformatf("v%0d_result_held", i), data_result, vecs[i].expResult);
      $display("vec %0d A=0x%08h B=0x%08h result=0x%08h exc=%0b rdy_cycle=%0d",
               i, vecs[i].a, vecs[i].b, res, exc, rdyCycle);
    end

    // Abort mid-RUN with a new start
    er  = expRdyCycle(32'd6);
    cut = (er - 1 < 10) ? er - 1 : 10;
    startOp(32'd7, 32'd6);
    observe(cut - 1, cut - 1, rdyCycle, rdyCount, res, exc, busyErr);
    check("abort_pre_rdy_count", rdyCount, 32'd0);
    check("abort_pre_busy_errs", busyErr, 32'd0);
    startOp(32'd2, 32'd3);
    er2 = expRdyCycle(32'd3);
    observe(er2 + 2, er2 - 1, rdyCycle, rdyCount, res, exc, busyErr);
    check("abort_rdy_cycle", cut + rdyCycle, cut + er2);
    check("abort_rdy_count", rdyCount, 32'd1);
    check("abort_result", res, 32'd6);
    $display("abort restart at cycle %0d result=0x%08h rdy_cycle=%0d", cut, res, cut + rdyCycle);

    // New start issued in the DONE cycle
    startOp(32'd7, 32'd6);
    observe(er - 1, er - 1, rdyCycle, rdyCount, res, exc, busyErr);
    check("done_pre_rdy_count", rdyCount, 32'd0);
    @(negedge clock);
    check("done_cycle_rdy", {31'd0, data_resultRDY}, 32'd1);
    check("done_cycle_result", data_result, 32'd42);
    check("done_cycle_busy", {31'd0, busy}, 32'd0);
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd3;
    data_operandB = 32'd4;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    er2 = expRdyCycle(32'd4);
    observe(er2 + 1, er2 - 1, rdyCycle, rdyCount, res, exc, busyErr);
    check("done_restart_rdy_cycle", rdyCycle, er2);
    check("done_restart_rdy_count", rdyCount, 32'd1);
    check("done_restart_result", res, 32'd12);
    check("done_restart_busy_errs", busyErr, 32'd0);
    $display("restart in DONE result=0x%08h rdy_cycle=%0d", res, rdyCycle);

    // Asynchronous reset mid-operation
    cut = (er - 1 < 15) ? er - 1 : 15;
    startOp(32'd7, 32'd6);
    observe(cut - 1, cut - 1, rdyCycle, rdyCount, res, exc, busyErr);
    @(negedge clock);
    check("areset_busy_before", {31'd0, busy}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("areset_result", data_result, 32'd0);
    check("areset_exc", {31'd0, data_exception}, 32'd0);
    check("areset_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("areset_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    observe(40, 0, rdyCycle, rdyCount, res, exc, busyErr);
    check("areset_no_rdy", rdyCount, 32'd0);
    check("areset_idle_busy_errs", busyErr, 32'd0);
    startOp(32'd5, 32'hFFFFFFFC);
    er2 = expRdyCycle(32'hFFFFFFFC);
    observe(er2 + 1, er2 - 1, rdyCycle, rdyCount, res, exc, busyErr);
    check("areset_fresh_rdy_cycle", rdyCycle, er2);
    check("areset_fresh_result", res, 32'hFFFFFFEC);
    check("areset_fresh_exc", {31'd0, exc}, 32'd0);
    $display("reset at cycle %0d then fresh op result=0x%08h rdy_cycle=%0d", cut, res, rdyCycle);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
